// File: rtl/irq_exc_ctrl_pkg.sv
// rtl/irq_exc_ctrl_pkg.sv - shared state encoding, cause layout and default vectors
package irq_pkg;

  typedef enum logic [1:0] {
    ST_USER  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_SUPER = 2'd2
  } trap_state_e;

  localparam int CAUSE_W       = 8;
  localparam int CAUSE_IRQ_BIT = 7;
  localparam int CAUSE_IDX_MSB = 3;

  localparam logic [31:0] IRQ_VEC_DEFAULT = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h8000_0008;

endpackage

// File: rtl/irq_exc_ctrl_if.sv
// rtl/irq_exc_ctrl_if.sv - pipeline <-> trap controller signal bundle
interface irq_exc_ctrl_if #(
  parameter int N_IRQ = 4,
  parameter int XLEN  = 32
);
  import irq_pkg::*;

  logic [N_IRQ-1:0]   irq;
  logic               mask_we;
  logic [N_IRQ-1:0]   mask_wdata;
  logic               inst_valid;
  logic               stall;
  logic [XLEN-1:0]    inst_pc;
  logic               exc_req;
  logic               eret;

  logic               trap_taken;
  logic               trap_is_irq;
  logic [XLEN-1:0]    trap_vector;
  logic [XLEN-1:0]    epc;
  logic [CAUSE_W-1:0] cause;
  logic               supervised;
  logic [N_IRQ-1:0]   pending;
  logic [N_IRQ-1:0]   mask;

  modport master (
    output irq, mask_we, mask_wdata, inst_valid, stall, inst_pc, exc_req, eret,
    input  trap_taken, trap_is_irq, trap_vector, epc, cause, supervised, pending, mask
  );

  modport slave (
    input  irq, mask_we, mask_wdata, inst_valid, stall, inst_pc, exc_req, eret,
    output trap_taken, trap_is_irq, trap_vector, epc, cause, supervised, pending, mask
  );

endinterface

// File: rtl/irq_exc_ctrl_sync_edge.sv
// rtl/irq_exc_ctrl_sync_edge.sv - per-line synchroniser with rising-edge pulse
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_exc_ctrl.sv
// rtl/irq_exc_ctrl.sv - interrupt/exception trap controller with supervisor-mode FSM
module irq_exc_ctrl
  import irq_pkg::*;
#(
  parameter int              N_IRQ       = 4,
  parameter int              XLEN        = 32,
  parameter int              SYNC_STAGES = 2,
  parameter logic [XLEN-1:0] IRQ_VEC     = IRQ_VEC_DEFAULT,
  parameter logic [XLEN-1:0] EXC_VEC     = EXC_VEC_DEFAULT
) (
  input logic          clk,
  input logic          reset_n,
  irq_exc_ctrl_if.slave bus
);

  trap_state_e        state_q, state_d;
  logic [N_IRQ-1:0]   pending_q, mask_q, rise, eligible, win_oh, clr;
  logic [3:0]         win_idx;
  logic               adv, take_irq, take_exc;
  logic               trap_taken_q, trap_is_irq_q;
  logic [XLEN-1:0]    trap_vector_q, epc_q;
  logic [CAUSE_W-1:0] cause_q, cause_irq;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (bus.irq[g]),
      .rise_o  (rise[g])
    );
  end

  assign eligible = pending_q & mask_q;
  assign adv      = bus.inst_valid & ~bus.stall;

  // Walk downward so the lowest eligible index is the last one written.
  always_comb begin
    win_idx = '0;
    win_oh  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx    = 4'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
      end
    end
  end

  always_comb begin
    cause_irq                   = '0;
    cause_irq[CAUSE_IRQ_BIT]    = 1'b1;
    cause_irq[CAUSE_IDX_MSB:0]  = win_idx;
  end

  always_comb begin
    state_d  = state_q;
    take_irq = 1'b0;
    take_exc = 1'b0;
    case (state_q)
      ST_USER: begin
        if (adv && (eligible != '0)) begin
          state_d  = ST_TRAP;
          take_irq = 1'b1;
        end else if (adv && bus.exc_req) begin
          state_d  = ST_TRAP;
          take_exc = 1'b1;
        end
      end
      ST_TRAP:  state_d = ST_SUPER;
      ST_SUPER: if (adv && bus.eret) state_d = ST_USER;
      default:  state_d = ST_USER;
    endcase
  end

  // A fresh edge on the line being taken re-sets its pending bit.
  assign clr = take_irq ? win_oh : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_USER;
      pending_q     <= '0;
      mask_q        <= '1;
      trap_taken_q  <= 1'b0;
      trap_is_irq_q <= 1'b0;
      trap_vector_q <= '0;
      epc_q         <= '0;
      cause_q       <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= (pending_q & ~clr) | rise;
      trap_taken_q <= take_irq | take_exc;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      if (take_irq || take_exc) begin
        trap_is_irq_q <= take_irq;
        trap_vector_q <= take_irq ? IRQ_VEC : EXC_VEC;
        epc_q         <= bus.inst_pc;
        cause_q       <= take_irq ? cause_irq : '0;
      end
    end
  end

  assign bus.trap_taken  = trap_taken_q;
  assign bus.trap_is_irq = trap_is_irq_q;
  assign bus.trap_vector = trap_vector_q;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;
  assign bus.supervised  = (state_q != ST_USER);
  assign bus.pending     = pending_q;
  assign bus.mask        = mask_q;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// tb/tb_irq_exc_ctrl.sv - scoreboard bench for irq_exc_ctrl
module tb_irq_exc_ctrl;

  localparam logic [31:0] IRQ_V = 32'h8000_0004;
  localparam logic [31:0] EXC_V = 32'h8000_0008;
  localparam logic [82:0] RESET_BLOB = {1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 4'h0, 4'hF};

  typedef struct packed {
    logic        is_irq;
    logic [31:0] vec;
    logic [7:0]  cause;
    logic [31:0] epc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  irq_exc_ctrl_if #(.N_IRQ(4), .XLEN(32)) bus ();

  irq_exc_ctrl #(
    .N_IRQ(4), .XLEN(32), .SYNC_STAGES(2), .IRQ_VEC(IRQ_V), .EXC_VEC(EXC_V)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  function automatic logic [82:0] blob();
    return {bus.trap_taken, bus.trap_is_irq, bus.trap_vector, bus.epc, bus.cause,
            bus.supervised, bus.pending, bus.mask};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic is_irq, logic [31:0] vec, logic [7:0] cause, logic [31:0] epc);
    exp_t e;
    e.is_irq = is_irq; e.vec = vec; e.cause = cause; e.epc = epc;
    exp_q.push_back(e);
  endtask

  // Monitor: every trap pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.trap_taken) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_trap", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("trap_is_irq", bus.trap_is_irq, e.is_irq);
        chk("trap_vector", bus.trap_vector, e.vec);
        chk("cause", bus.cause, e.cause);
        chk("epc", bus.epc, e.epc);
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    bus.irq        = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.inst_valid = 1'b0;
    bus.stall      = 1'b0;
    bus.inst_pc    = '0;
    bus.exc_req    = 1'b0;
    bus.eret       = 1'b0;
    tick(3);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outputs", blob(), RESET_BLOB);
    end

    // Single IRQ on line 2
    bus.inst_valid = 1'b1;
    bus.inst_pc    = 32'h0040_0010;
    bus.irq        = 4'b0100;
    tick(2);
    chk("pending_not_yet", bus.pending, 4'b0000);
    tick();
    chk("pending2_set", bus.pending, 4'b0100);
    chk("no_trap_before_pending", bus.trap_taken, 1'b0);
    push(1'b1, IRQ_V, 8'h82, 32'h0040_0010);
    tick();
    chk("irq2_trap_pulse", bus.trap_taken, 1'b1);
    chk("pending2_cleared", bus.pending, 4'b0000);
    chk("supervised_in_trap", bus.supervised, 1'b1);
    tick();
    chk("pulse_one_cycle", bus.trap_taken, 1'b0);
    chk("vector_held", bus.trap_vector, IRQ_V);
    chk("supervised_super", bus.supervised, 1'b1);

    // IRQ 1 and 3 latch in SUPER, then IRQ beats a same-cycle exception
    bus.irq = 4'b1110;
    tick(3);
    chk("pending_1_3_in_super", bus.pending, 4'b1010);
    bus.eret = 1'b1;
    tick();
    chk("eret_to_user", bus.supervised, 1'b0);
    bus.eret    = 1'b0;
    bus.exc_req = 1'b1;
    bus.inst_pc = 32'h0040_0030;
    push(1'b1, IRQ_V, 8'h81, 32'h0040_0030);
    tick();
    chk("irq1_over_exc", bus.trap_taken, 1'b1);
    chk("pending_after_irq1", bus.pending, 4'b1000);
    bus.exc_req = 1'b0;
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret    = 1'b0;
    bus.inst_pc = 32'h0040_0040;
    push(1'b1, IRQ_V, 8'h83, 32'h0040_0040);
    tick();
    chk("pending_after_irq3", bus.pending, 4'b0000);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    chk("user_after_irq3", bus.supervised, 1'b0);

    // Exception in USER, ignored in SUPER
    bus.exc_req = 1'b1;
    bus.inst_pc = 32'h0040_0020;
    push(1'b0, EXC_V, 8'h00, 32'h0040_0020);
    tick();
    chk("exc_trap_pulse", bus.trap_taken, 1'b1);
    bus.inst_pc = 32'h0040_0024;
    tick(3);
    chk("exc_ignored_super", bus.trap_taken, 1'b0);
    chk("exc_vector_held", bus.trap_vector, EXC_V);
    chk("epc_held", bus.epc, 32'h0040_0020);
    bus.exc_req = 1'b0;
    bus.eret    = 1'b1;
    tick();
    chk("eret_after_exc", bus.supervised, 1'b0);
    bus.eret = 1'b0;

    // Stalls and bubbles never take a trap
    bus.exc_req = 1'b1;
    bus.stall   = 1'b1;
    tick(2);
    chk("no_trap_on_stall", bus.supervised, 1'b0);
    bus.stall      = 1'b0;
    bus.inst_valid = 1'b0;
    tick(2);
    chk("no_trap_on_bubble", bus.supervised, 1'b0);
    bus.exc_req    = 1'b0;
    bus.inst_valid = 1'b1;

    // Masked IRQ 0, then unmask
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b0000;
    tick();
    bus.mask_we = 1'b0;
    chk("mask_cleared", bus.mask, 4'b0000);
    bus.irq = 4'b1111;
    tick(3);
    chk("pending0_masked", bus.pending, 4'b0001);
    tick(3);
    chk("masked_no_trap", bus.supervised, 1'b0);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b0001;
    bus.inst_pc    = 32'h0040_0050;
    push(1'b1, IRQ_V, 8'h80, 32'h0040_0050);
    tick();
    bus.mask_we = 1'b0;
    chk("mask_written", bus.mask, 4'b0001);
    chk("old_mask_same_cycle", bus.trap_taken, 1'b0);
    tick();
    chk("unmasked_trap", bus.trap_taken, 1'b1);
    chk("pending0_cleared", bus.pending, 4'b0000);

    // Reset in the middle of the TRAP cycle
    @(negedge clk);
    #1;
    reset_n        = 1'b0;
    bus.irq        = '0;
    bus.inst_valid = 1'b0;
    #1;
    chk("reset_mid_trap", blob(), RESET_BLOB);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    chk("after_reset_idle", blob(), RESET_BLOB);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
